// File: rtl/add_rs_bank_pkg.sv
// Shared constants for the adder reservation-station bank: CDB tag map,
// opcodes and the per-entry state encoding.
package rs_pkg;

    localparam int TAG_NONE    = 0;
    localparam int TAG_ADD1    = 1;
    localparam int TAG_ADD2    = 2;
    localparam int TAG_ADD3    = 3;
    localparam int TAG_MUL1    = 4;
    localparam int TAG_MUL2    = 5;
    localparam int TAG_LS_BASE = 8;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;

    localparam int NUM_ENTRIES = 3;
    localparam int NUM_LANES   = 6;

    typedef enum logic [2:0] {
        ST_FREE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_READY = 3'd2,
        ST_EXEC  = 3'd3,
        ST_DONE  = 3'd4
    } ent_state_e;

endpackage

// File: rtl/add_rs_bank_if.sv
// Issue, common-data-bus and result/busy signals between the order manager
// (master) and the adder reservation-station bank (slave).
interface add_rs_bank_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
);
    logic              issue_valid;
    logic [TAG_W-1:0]  issue_rs_idx;
    logic [2:0]        issue_op;
    logic [DATA_W-1:0] Vj_in;
    logic [DATA_W-1:0] Vk_in;
    logic [TAG_W-1:0]  Qj_in;
    logic [TAG_W-1:0]  Qk_in;
    logic              MULT1_valid;
    logic              MULT2_valid;
    logic              LS_valid;
    logic [DATA_W-1:0] MULT1_result;
    logic [DATA_W-1:0] MULT2_result;
    logic [DATA_W-1:0] LS_value;
    logic [2:0]        LS_idx;
    logic              busy_add1;
    logic              busy_add2;
    logic              busy_add3;
    logic              ADD1_valid;
    logic              ADD2_valid;
    logic              ADD3_valid;
    logic [DATA_W-1:0] ADD1_result;
    logic [DATA_W-1:0] ADD2_result;
    logic [DATA_W-1:0] ADD3_result;

    modport master (
        output issue_valid, issue_rs_idx, issue_op, Vj_in, Vk_in, Qj_in, Qk_in,
        output MULT1_valid, MULT2_valid, LS_valid, MULT1_result, MULT2_result,
        output LS_value, LS_idx,
        input  busy_add1, busy_add2, busy_add3,
        input  ADD1_valid, ADD2_valid, ADD3_valid,
        input  ADD1_result, ADD2_result, ADD3_result
    );

    modport slave (
        input  issue_valid, issue_rs_idx, issue_op, Vj_in, Vk_in, Qj_in, Qk_in,
        input  MULT1_valid, MULT2_valid, LS_valid, MULT1_result, MULT2_result,
        input  LS_value, LS_idx,
        output busy_add1, busy_add2, busy_add3,
        output ADD1_valid, ADD2_valid, ADD3_valid,
        output ADD1_result, ADD2_result, ADD3_result
    );

endinterface

// File: rtl/add_rs_bank_rs_entry.sv
// One reservation-station entry: operand capture at issue, CDB snoop for
// missing operands, and the FREE/WAIT/READY/EXEC/DONE lifecycle.
module rs_entry
    import rs_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               issue_en,
    input  logic [2:0]                         issue_op,
    input  logic [DATA_W-1:0]                  vj_in,
    input  logic [DATA_W-1:0]                  vk_in,
    input  logic [TAG_W-1:0]                   qj_in,
    input  logic [TAG_W-1:0]                   qk_in,
    input  logic [NUM_LANES-1:0]               lane_valid,
    input  logic [NUM_LANES-1:0][TAG_W-1:0]    lane_tag,
    input  logic [NUM_LANES-1:0][DATA_W-1:0]   lane_data,
    input  logic                               dispatch,
    input  logic                               done,
    output logic                               busy,
    output logic                               ready,
    output logic [2:0]                         op,
    output logic [DATA_W-1:0]                  vj,
    output logic [DATA_W-1:0]                  vk
);

    ent_state_e        state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [DATA_W-1:0] vj_q, vj_d, vk_q, vk_d;
    logic [TAG_W-1:0]  qj_q, qj_d, qk_q, qk_d;
    logic [TAG_W-1:0]  tag_j_s, tag_k_s;
    logic              hit_j_s, hit_k_s;
    logic [DATA_W-1:0] dat_j_s, dat_k_s;

    // Tag 0 means "value present", so it never matches a lane.
    function automatic logic lane_match(input logic [TAG_W-1:0] q,
                                        input logic [NUM_LANES-1:0] v,
                                        input logic [NUM_LANES-1:0][TAG_W-1:0] t);
        logic m;
        m = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            m = m | (v[i] & (t[i] == q) & (q != {TAG_W{1'b0}}));
        end
        return m;
    endfunction

    function automatic logic [DATA_W-1:0] lane_pick(input logic [TAG_W-1:0] q,
                                                    input logic [NUM_LANES-1:0] v,
                                                    input logic [NUM_LANES-1:0][TAG_W-1:0] t,
                                                    input logic [NUM_LANES-1:0][DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
        r = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_LANES; i++) begin
            r = r | ({DATA_W{v[i] & (t[i] == q)}} & d[i]);
        end
        return r;
    endfunction

    // Compare against the incoming tags while free (bypass) and stored tags otherwise (snoop).
    always_comb begin
        tag_j_s = (state_q == ST_FREE) ? qj_in : qj_q;
        tag_k_s = (state_q == ST_FREE) ? qk_in : qk_q;
        hit_j_s = lane_match(tag_j_s, lane_valid, lane_tag);
        hit_k_s = lane_match(tag_k_s, lane_valid, lane_tag);
        dat_j_s = lane_pick(tag_j_s, lane_valid, lane_tag, lane_data);
        dat_k_s = lane_pick(tag_k_s, lane_valid, lane_tag, lane_data);
    end

    // Entry state and operand registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FREE;
            op_q    <= OP_ADD;
            vj_q    <= {DATA_W{1'b0}};
            vk_q    <= {DATA_W{1'b0}};
            qj_q    <= {TAG_W{1'b0}};
            qk_q    <= {TAG_W{1'b0}};
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            vj_q    <= vj_d;
            vk_q    <= vk_d;
            qj_q    <= qj_d;
            qk_q    <= qk_d;
        end
    end

    // Next-state and operand capture.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        vj_d    = vj_q;
        vk_d    = vk_q;
        qj_d    = qj_q;
        qk_d    = qk_q;
        case (state_q)
            ST_FREE: begin
                if (issue_en) begin
                    op_d    = issue_op;
                    vj_d    = hit_j_s ? dat_j_s : vj_in;
                    qj_d    = hit_j_s ? {TAG_W{1'b0}} : qj_in;
                    vk_d    = hit_k_s ? dat_k_s : vk_in;
                    qk_d    = hit_k_s ? {TAG_W{1'b0}} : qk_in;
                    state_d = ((qj_d == {TAG_W{1'b0}}) && (qk_d == {TAG_W{1'b0}}))
                              ? ST_READY : ST_WAIT;
                end else begin
                    state_d = ST_FREE;
                end
            end
            ST_WAIT: begin
                if (hit_j_s) begin
                    vj_d = dat_j_s;
                    qj_d = {TAG_W{1'b0}};
                end else begin
                    qj_d = qj_q;
                end
                if (hit_k_s) begin
                    vk_d = dat_k_s;
                    qk_d = {TAG_W{1'b0}};
                end else begin
                    qk_d = qk_q;
                end
                state_d = ((qj_d == {TAG_W{1'b0}}) && (qk_d == {TAG_W{1'b0}}))
                          ? ST_READY : ST_WAIT;
            end
            ST_READY: state_d = dispatch ? ST_EXEC : ST_READY;
            ST_EXEC:  state_d = done ? ST_DONE : ST_EXEC;
            ST_DONE:  state_d = ST_FREE;
            default:  state_d = ST_FREE;
        endcase
    end

    // Status and operand outputs.
    always_comb begin
        busy  = (state_q != ST_FREE);
        ready = (state_q == ST_READY);
        op    = op_q;
        vj    = vj_q;
        vk    = vk_q;
    end

endmodule

// File: rtl/add_rs_bank.sv
// Three-entry adder reservation-station bank with a shared non-pipelined
// adder, lowest-index dispatch and one ADDn result lane per entry.
module add_rs_bank
    import rs_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 4,
    parameter int ADD_LAT = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    add_rs_bank_if.slave bus
);

    localparam int CNT_W = (ADD_LAT < 2) ? 1 : $clog2(ADD_LAT + 1);

    logic [NUM_LANES-1:0]                 lane_valid_s;
    logic [NUM_LANES-1:0][TAG_W-1:0]      lane_tag_s;
    logic [NUM_LANES-1:0][DATA_W-1:0]     lane_data_s;
    logic [NUM_ENTRIES-1:0]               issue_en_s, busy_s, ready_s, dispatch_s, done_s;
    logic [NUM_ENTRIES-1:0][2:0]          op_s;
    logic [NUM_ENTRIES-1:0][DATA_W-1:0]   vj_s, vk_s;

    logic                                 alu_busy_q, alu_busy_d;
    logic [CNT_W-1:0]                     cnt_q, cnt_d;
    logic [1:0]                           sel_q, sel_d;
    logic [NUM_ENTRIES-1:0]               valid_q, valid_d;
    logic [NUM_ENTRIES-1:0][DATA_W-1:0]   result_q, result_d;

    function automatic logic [DATA_W-1:0] alu_calc(input logic [2:0] op,
                                                   input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        case (op)
            OP_SUB:  return a - b;
            default: return a + b;
        endcase
    endfunction

    // Six CDB lanes; this bank's own results are lanes 0..2.
    always_comb begin
        lane_valid_s = {bus.LS_valid, bus.MULT2_valid, bus.MULT1_valid,
                        valid_q[2], valid_q[1], valid_q[0]};
        lane_tag_s[0]  = TAG_W'(TAG_ADD1);
        lane_tag_s[1]  = TAG_W'(TAG_ADD2);
        lane_tag_s[2]  = TAG_W'(TAG_ADD3);
        lane_tag_s[3]  = TAG_W'(TAG_MUL1);
        lane_tag_s[4]  = TAG_W'(TAG_MUL2);
        lane_tag_s[5]  = TAG_W'(TAG_LS_BASE) + TAG_W'(bus.LS_idx);
        lane_data_s[0] = result_q[0];
        lane_data_s[1] = result_q[1];
        lane_data_s[2] = result_q[2];
        lane_data_s[3] = bus.MULT1_result;
        lane_data_s[4] = bus.MULT2_result;
        lane_data_s[5] = bus.LS_value;
    end

    for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_ent
        assign issue_en_s[i] = bus.issue_valid && (bus.issue_rs_idx == TAG_W'(TAG_ADD1 + i));

        rs_entry #(.DATA_W(DATA_W), .TAG_W(TAG_W)) u_entry (
            .clk        (clk),
            .rst_n      (rst_n),
            .issue_en   (issue_en_s[i]),
            .issue_op   (bus.issue_op),
            .vj_in      (bus.Vj_in),
            .vk_in      (bus.Vk_in),
            .qj_in      (bus.Qj_in),
            .qk_in      (bus.Qk_in),
            .lane_valid (lane_valid_s),
            .lane_tag   (lane_tag_s),
            .lane_data  (lane_data_s),
            .dispatch   (dispatch_s[i]),
            .done       (done_s[i]),
            .busy       (busy_s[i]),
            .ready      (ready_s[i]),
            .op         (op_s[i]),
            .vj         (vj_s[i]),
            .vk         (vk_s[i])
        );
    end

    // Fixed-priority dispatch, only while the adder is idle.
    always_comb begin
        dispatch_s = 3'b000;
        if (!alu_busy_q) begin
            if (ready_s[0])      dispatch_s = 3'b001;
            else if (ready_s[1]) dispatch_s = 3'b010;
            else if (ready_s[2]) dispatch_s = 3'b100;
            else                 dispatch_s = 3'b000;
        end else begin
            dispatch_s = 3'b000;
        end
    end

    // Adder state, counter and result lane registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_busy_q <= 1'b0;
            cnt_q      <= {CNT_W{1'b0}};
            sel_q      <= 2'd0;
            valid_q    <= 3'b000;
            result_q   <= '0;
        end else begin
            alu_busy_q <= alu_busy_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            valid_q    <= valid_d;
            result_q   <= result_d;
        end
    end

    // Completion frees the adder in the valid cycle, so the next dispatch follows directly.
    always_comb begin
        alu_busy_d = alu_busy_q;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        valid_d    = 3'b000;
        result_d   = result_q;
        done_s     = 3'b000;
        if (alu_busy_q) begin
            if (cnt_q == CNT_W'(1)) begin
                alu_busy_d = 1'b0;
                cnt_d      = {CNT_W{1'b0}};
                for (int i = 0; i < NUM_ENTRIES; i++) begin
                    if (sel_q == 2'(i)) begin
                        valid_d[i]  = 1'b1;
                        done_s[i]   = 1'b1;
                        result_d[i] = alu_calc(op_s[i], vj_s[i], vk_s[i]);
                    end else begin
                        valid_d[i]  = 1'b0;
                    end
                end
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else if (dispatch_s != 3'b000) begin
            alu_busy_d = 1'b1;
            cnt_d      = CNT_W'(ADD_LAT);
            case (dispatch_s)
                3'b001:  sel_d = 2'd0;
                3'b010:  sel_d = 2'd1;
                3'b100:  sel_d = 2'd2;
                default: sel_d = sel_q;
            endcase
        end else begin
            alu_busy_d = 1'b0;
        end
    end

    // Output drive.
    always_comb begin
        bus.busy_add1   = busy_s[0];
        bus.busy_add2   = busy_s[1];
        bus.busy_add3   = busy_s[2];
        bus.ADD1_valid  = valid_q[0];
        bus.ADD2_valid  = valid_q[1];
        bus.ADD3_valid  = valid_q[2];
        bus.ADD1_result = result_q[0];
        bus.ADD2_result = result_q[1];
        bus.ADD3_result = result_q[2];
    end

endmodule

// File: tb/tb_add_rs_bank.sv
// Directed bench for add_rs_bank: latency, wakeup, bypass, arbitration/chaining,
// protocol corner cases and mid-operation reset.
module tb_add_rs_bank;
    import rs_pkg::*;

    logic clk;
    logic rst_n;
    int   checks_cnt;
    int   errors_cnt;

    add_rs_bank_if #(.DATA_W(32), .TAG_W(4)) bif ();

    add_rs_bank #(.DATA_W(32), .TAG_W(4), .ADD_LAT(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_lanes(input string tag, input logic [2:0] exp);
        check_eq(tag, {29'd0, bif.ADD1_valid, bif.ADD2_valid, bif.ADD3_valid}, {29'd0, exp});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bif.issue_valid  = 1'b0;
        bif.issue_rs_idx = 4'd0;
        bif.issue_op     = 3'b000;
        bif.Vj_in        = 32'd0;
        bif.Vk_in        = 32'd0;
        bif.Qj_in        = 4'd0;
        bif.Qk_in        = 4'd0;
        bif.MULT1_valid  = 1'b0;
        bif.MULT2_valid  = 1'b0;
        bif.LS_valid     = 1'b0;
        bif.MULT1_result = 32'd0;
        bif.MULT2_result = 32'd0;
        bif.LS_value     = 32'd0;
        bif.LS_idx       = 3'd0;
    endtask

    task automatic drive_issue(input logic [3:0] idx, input logic [2:0] op,
                               input logic [31:0] vj, input logic [31:0] vk,
                               input logic [3:0] qj, input logic [3:0] qk);
        bif.issue_valid  = 1'b1;
        bif.issue_rs_idx = idx;
        bif.issue_op     = op;
        bif.Vj_in        = vj;
        bif.Vk_in        = vk;
        bif.Qj_in        = qj;
        bif.Qk_in        = qk;
    endtask

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        idle();
        rst_n = 1'b0;
        step();
        step();
        check_eq("rst_busy", {29'd0, bif.busy_add1, bif.busy_add2, bif.busy_add3}, 32'd0);
        check_lanes("rst_valid", 3'b000);
        check_eq("rst_res1", bif.ADD1_result, 32'd0);
        check_eq("rst_res3", bif.ADD3_result, 32'd0);
        #4 rst_n = 1'b1;
        step();

        // Ready issue: 5+7, valid 3 cycles after issue, busy for 4 cycles.
        drive_issue(4'd1, OP_ADD, 32'd5, 32'd7, 4'd0, 4'd0);
        step();
        idle();
        for (int k = 0; k < 5; k++) begin
            check_eq("t1_busy1", {31'd0, bif.busy_add1}, (k < 4) ? 32'd1 : 32'd0);
            check_lanes("t1_valid", (k == 3) ? 3'b100 : 3'b000);
            if (k == 3) check_eq("t1_res", bif.ADD1_result, 32'd12);
            if (k != 4) step();
        end

        // CDB wakeup: 20 - MULT1(3), tag 4 arrives three cycles after issue.
        drive_issue(4'd2, OP_SUB, 32'd20, 32'd0, 4'd0, 4'd4);
        step();
        idle();
        check_eq("t2_busy2", {31'd0, bif.busy_add2}, 32'd1);
        step();
        check_lanes("t2_wait_a", 3'b000);
        step();
        check_lanes("t2_wait_b", 3'b000);
        bif.MULT1_valid  = 1'b1;
        bif.MULT1_result = 32'd3;
        step();
        idle();
        check_lanes("t2_snoop", 3'b000);
        for (int k = 1; k <= 3; k++) begin
            step();
            check_lanes("t2_valid", (k == 3) ? 3'b010 : 3'b000);
            if (k == 3) check_eq("t2_res", bif.ADD2_result, 32'd17);
        end
        step();
        check_eq("t2_release", {31'd0, bif.busy_add2}, 32'd0);

        // Same-cycle bypass from LS entry 5 (tag 13): 100 + 1.
        drive_issue(4'd3, OP_ADD, 32'd0, 32'd1, 4'd13, 4'd0);
        bif.LS_valid = 1'b1;
        bif.LS_idx   = 3'd5;
        bif.LS_value = 32'd100;
        step();
        idle();
        for (int k = 1; k <= 3; k++) begin
            step();
            check_lanes("t3_valid", (k == 3) ? 3'b001 : 3'b000);
            if (k == 3) check_eq("t3_res", bif.ADD3_result, 32'd101);
        end
        step();
        check_eq("t3_release", {31'd0, bif.busy_add3}, 32'd0);

        // Arbitration and chaining: 10+20, 50-8, then ADD1 result + 1000.
        drive_issue(4'd1, OP_ADD, 32'd10, 32'd20, 4'd0, 4'd0);
        step();
        drive_issue(4'd2, OP_SUB, 32'd50, 32'd8, 4'd0, 4'd0);
        step();
        drive_issue(4'd3, OP_ADD, 32'd0, 32'd1000, 4'd1, 4'd0);
        step();
        idle();
        for (int k = 1; k <= 8; k++) begin
            step();
            check_lanes("t4_order", (k == 1) ? 3'b100 : (k == 4) ? 3'b010 :
                                    (k == 7) ? 3'b001 : 3'b000);
            if (k == 1) check_eq("t4_res1", bif.ADD1_result, 32'd30);
            if (k == 4) check_eq("t4_res2", bif.ADD2_result, 32'd42);
            if (k == 7) check_eq("t4_res3", bif.ADD3_result, 32'd1030);
        end
        check_eq("t4_busy_all", {29'd0, bif.busy_add1, bif.busy_add2, bif.busy_add3}, 32'd0);

        // Wrap-around, issue to a busy entry, issue to a non-ADD tag.
        drive_issue(4'd1, OP_ADD, 32'hFFFF_FFFF, 32'd1, 4'd0, 4'd0);
        step();
        drive_issue(4'd1, OP_ADD, 32'd3, 32'd4, 4'd0, 4'd0);
        step();
        drive_issue(4'd4, OP_ADD, 32'd9, 32'd9, 4'd0, 4'd0);
        step();
        idle();
        check_eq("t5_busy23", {30'd0, bif.busy_add2, bif.busy_add3}, 32'd0);
        check_lanes("t5_pre", 3'b000);
        step();
        check_lanes("t5_valid", 3'b100);
        check_eq("t5_wrap", bif.ADD1_result, 32'd0);
        step();
        check_eq("t5_release", {31'd0, bif.busy_add1}, 32'd0);
        check_eq("t5_hold", bif.ADD1_result, 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check_lanes("t5_no_stale", 3'b000);
        end

        // Asynchronous reset while entry 2 is executing.
        drive_issue(4'd2, OP_ADD, 32'd1, 32'd2, 4'd0, 4'd0);
        step();
        idle();
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        check_eq("t6_busy", {29'd0, bif.busy_add1, bif.busy_add2, bif.busy_add3}, 32'd0);
        check_lanes("t6_valid", 3'b000);
        check_eq("t6_res2", bif.ADD2_result, 32'd0);
        #2 rst_n = 1'b1;
        step();
        check_lanes("t6_post_a", 3'b000);
        step();
        check_lanes("t6_post_b", 3'b000);
        drive_issue(4'd2, OP_ADD, 32'd6, 32'd7, 4'd0, 4'd0);
        step();
        idle();
        for (int k = 1; k <= 3; k++) begin
            step();
            check_lanes("t6_fresh", (k == 3) ? 3'b010 : 3'b000);
            if (k == 3) check_eq("t6_res", bif.ADD2_result, 32'd13);
        end

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/add_rs_bank.md
Name: add_rs_bank

Overview:
- Three-entry adder reservation-station bank (ADD1..ADD3); the consumer side of the issue interface driven by the order manager.
- Accepts issued instructions tagged with rs_idx/Qj/Qk, snoops the common data bus for missing operands, and dispatches ready entries to one shared, non-pipelined adder.
- Broadcasts results on ADD1..ADD3 CDB lanes and reports per-entry busy back to the order manager.

Parameters:
- DATA_W, 32, operand/result width.
- TAG_W, 4, reservation-station tag width.
- ADD_LAT, 2, adder cycles from dispatch to result register (>=1).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- issue_valid  in  1  issue strobe (order manager start and no struct_haz)
- issue_rs_idx  in  TAG_W  target station tag
- issue_op  in  3  000 ADD, 001 SUB, others treated as ADD
- Vj_in, Vk_in  in  DATA_W  register-file operand values
- Qj_in, Qk_in  in  TAG_W  producer tags; 0 = value valid
- MULT1_valid, MULT2_valid, LS_valid  in  1  CDB strobes
- MULT1_result, MULT2_result, LS_value  in  DATA_W  CDB data
- LS_idx  in  3  load/store entry index
- busy_add1, busy_add2, busy_add3  out  1  entry occupied
- ADD1_valid, ADD2_valid, ADD3_valid  out  1  one-cycle result broadcast
- ADD1_result, ADD2_result, ADD3_result  out  DATA_W  result data

Behaviour:
- Tag map (fixed): 0 none; 1-3 ADD1-3; 4-5 MULT1-2; 8+LS_idx for LS; 6, 7 unused.
- Reset: all entries freed; every busy, valid and result output is 0; ALU idle. Reset mid-operation discards all in-flight work.
- Issue: on an edge with issue_valid and issue_rs_idx in 1..3 and that entry not busy, latch op/V/Q. Busy is high from the next cycle.
  - Issue to a busy entry or a non-ADD tag is ignored: no state change.
- Issue bypass: if Qj_in or Qk_in matches a tag broadcast in the same cycle (any lane, including this bank's own ADDn lanes), capture the broadcast value and store Q=0.
- Snoop: each busy entry with Qj!=0 (Qk!=0) compares its tag against all six lanes every cycle. On a match, V<=lane data and Q<=0 at that edge.
  - Multiple lanes asserting the same tag is illegal and need not be handled.
- Per-entry state: FREE -> WAIT (any Q!=0) -> READY (Qj=Qk=0) -> EXEC (dispatched) -> DONE -> FREE.
  - An issue with both Q=0, or resolved by bypass, enters READY directly.
  - A snoop resolving the last operand moves WAIT->READY at that edge.
- Dispatch: when the ALU is idle, the lowest-index READY entry dispatches at the edge; the ALU goes busy.
  - A READY entry cannot dispatch in the same edge it became READY.
  - Other READY entries wait; no preemption.
- ALU: result = Vj+Vk (ADD) or Vj-Vk (SUB), modulo 2^DATA_W; no overflow flag.
  - A down-counter loaded with ADD_LAT decrements each cycle. When it reaches 0, the result register loads, ADDn_valid is asserted for exactly one cycle with ADDn_result, and the entry enters DONE.
  - The ALU is idle in the same cycle the valid is asserted, so a new dispatch may occur at that edge (back-to-back).
- Release: DONE -> FREE at the edge ending the valid cycle; busy_addn falls the cycle after ADDn_valid.
  - Re-issue to that entry is accepted from the cycle busy is low.
- Latency: issue edge with ready operands to ADDn_valid = ADD_LAT+1 cycles.
- ADDn_result holds its last value when valid is low; consumers must qualify it with valid.
- At most one ADDn_valid is high per cycle.
- Full bank: all busy high, so the order manager raises struct_haz; the bank needs no back-pressure port.

Decomposition:
- Shared package rs_pkg holds:
  - tag constants TAG_NONE, TAG_ADD1..3, TAG_MUL1..2, TAG_LS_BASE;
  - op codes OP_ADD, OP_SUB;
  - entry state encoding.
- Natural sub-module rs_entry, instantiated three times. It owns one entry's state, operand capture and snoop compare. It exports ready/busy and takes dispatch/done strobes.
- Dispatch arbiter, ALU counter and result lanes stay in add_rs_bank.

Test Plan:
- Ready issue: ADD tag 1, Vj=5, Vk=7, Q=0, ADD_LAT=2 -> ADD1_valid for 1 cycle exactly 3 cycles after issue, result 12; busy_add1 high for 4 cycles, then low.
- CDB wakeup: SUB tag 2, Vj=20, Qk=4; three cycles later MULT1_valid with result 3 -> dispatch next edge, ADD2_result=17 ADD_LAT+1 cycles after the snoop edge.
- Same-cycle bypass and LS tag: issue tag 3 with Qj=8+5 while LS_valid, LS_idx=5, LS_value=100 in the same cycle, Vk=1 -> entry READY immediately, ADD3_result=101.
- Arbitration and chaining: issue entries 1 and 2 ready, plus entry 3 waiting on tag 1 -> order ADD1, ADD2, ADD3 valids. Entry 3 uses ADD1's result. The ALU is never idle between back-to-back results.
- Wrap and protocol: 0xFFFFFFFF+1 -> 0. Issue to busy entry 1 -> ignored, original result unchanged. issue_rs_idx=4 -> ignored.
- Async reset asserted during EXEC -> all busy/valid 0 immediately. No stale ADDn_valid after release. A fresh issue then works normally.
